axis_frame_gen: RTL and testbench

Upstream AXI4-Stream traffic source for loopback bring-up. Emits frames of a programmable word length carrying a continuous incrementing data pattern, with TLAST on each frame's final word. Its M_AXIS port feeds the stream FIFO's S_AXIS, whose output is consumed by the frame-counting sink. Respects backpressure and never emits a truncated frame, so downstream word and frame counters can be checked exactly.

---
 rtl/axis_gen_pkg.sv | 16 +
 rtl/axis_frame_gen.sv | 129 ++++++++++++
 tb/tb_axis_frame_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_gen_pkg.sv
// Shared types and default widths for the AXI4-Stream frame generator.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

  localparam int W_DEF     = 32;
  localparam int LEN_W_DEF = 16;
  localparam int FRAMES_W  = 32;
  localparam int GAP_W     = 16;

endpackage

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: fixed-length frames of an incrementing word pattern.
// Define AXIS_FRAME_GEN_GAP_EN to add the gap_cycles port and inter-frame GAP state.
module axis_frame_gen
  import axis_gen_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                enable,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [FRAMES_W-1:0] num_frames,
`ifdef AXIS_FRAME_GEN_GAP_EN
  input  logic [GAP_W-1:0]    gap_cycles,
`endif
  output logic [W-1:0]        m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic [FRAMES_W-1:0] frames_sent
);

  gen_state_t          r_state;
  logic [W-1:0]        r_tdata;
  logic [LEN_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_len_m1;
  logic [FRAMES_W-1:0] r_left;
  logic                r_finite;
  logic                r_done;
  logic [FRAMES_W-1:0] r_frames_sent;
`ifdef AXIS_FRAME_GEN_GAP_EN
  logic [GAP_W-1:0]    r_gap_cnt;
`endif

  logic w_send;
  logic w_last;

  // A zero length behaves as a single-word frame.
  function automatic logic [LEN_W-1:0] len_m1_of(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_idx == r_len_m1);

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = w_send;
  assign m_axis_tlast  = w_last;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign frames_sent   = r_frames_sent;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state       <= IDLE;
      r_tdata       <= '0;
      r_idx         <= '0;
      r_len_m1      <= '0;
      r_left        <= '0;
      r_finite      <= 1'b0;
      r_done        <= 1'b0;
      r_frames_sent <= '0;
`ifdef AXIS_FRAME_GEN_GAP_EN
      r_gap_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_len_m1 <= len_m1_of(frame_len);
            r_left   <= num_frames;
            r_finite <= (num_frames != '0);
            r_idx    <= '0;
            r_state  <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            r_tdata <= r_tdata + W'(1);
            if (w_last) begin
              r_idx         <= '0;
              r_frames_sent <= r_frames_sent + FRAMES_W'(1);
              if (r_finite) r_left <= r_left - FRAMES_W'(1);
              // enable is only consulted at frame boundaries so frames are never truncated
              if (r_finite && (r_left == FRAMES_W'(1))) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else if (!enable) begin
                r_state <= IDLE;
`ifdef AXIS_FRAME_GEN_GAP_EN
              end else if (gap_cycles != '0) begin
                r_gap_cnt <= gap_cycles - GAP_W'(1);
                r_state   <= GAP;
`endif
              end else begin
                r_len_m1 <= len_m1_of(frame_len);
              end
            end else begin
              r_idx <= r_idx + LEN_W'(1);
            end
          end
        end
`ifdef AXIS_FRAME_GEN_GAP_EN
        GAP: begin
          if (r_gap_cnt == '0) begin
            if (enable) begin
              r_len_m1 <= len_m1_of(frame_len);
              r_state  <= SEND;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
`endif
        DONE: begin
          if (!enable) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen (default build; gap test when AXIS_FRAME_GEN_GAP_EN is defined).
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic        enable;
  logic [15:0] frame_len;
  logic [31:0] num_frames;
`ifdef AXIS_FRAME_GEN_GAP_EN
  logic [15:0] gap_cycles;
`endif
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  int          checks;
  int          failures;
  logic [31:0] exp_data;
  logic [31:0] exp_frames;

  always #5 clk = ~clk;

  axis_frame_gen #(.W(32), .LEN_W(16)) dut (
    .clk          (clk),
    .areset       (areset),
    .enable       (enable),
    .frame_len    (frame_len),
    .num_frames   (num_frames),
`ifdef AXIS_FRAME_GEN_GAP_EN
    .gap_cycles   (gap_cycles),
`endif
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done),
    .frames_sent  (frames_sent)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b0; frame_len = 16'd1; num_frames = 32'd1; m_axis_tready = 1'b1;
`ifdef AXIS_FRAME_GEN_GAP_EN
    gap_cycles = 16'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%0d want=0", m_axis_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (frames_sent !== 32'd0) begin failures++; $display("FAIL reset_frames got=%0d want=0", frames_sent); end
    areset = 1'b0;
    step();
    exp_data = 32'd0;
    exp_frames = 32'd0;
  endtask

  task automatic test_basic();
    int words, dones, gaps, last_cyc, done_cyc;
    frame_len = 16'd4; num_frames = 32'd3; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data) begin
      failures++; $display("FAIL basic_first_word got=%b/%0d want=1/%0d", m_axis_tvalid, m_axis_tdata, exp_data); end
    words = 0; dones = 0; gaps = 0; last_cyc = -1; done_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data) begin failures++; $display("FAIL basic_data got=%0d want=%0d", m_axis_tdata, exp_data); end
        checks++; if (m_axis_tlast !== ((words % 4) == 3)) begin failures++; $display("FAIL basic_tlast word=%0d got=%b", words, m_axis_tlast); end
        if (m_axis_tlast) exp_frames++;
        exp_data++; words++; last_cyc = c;
      end else if (words > 0 && words < 12) gaps++;
      step();
      if (done) begin
        dones++; done_cyc = c;
        checks++; if (frames_sent !== exp_frames) begin failures++; $display("FAIL basic_frames_at_done got=%0d want=%0d", frames_sent, exp_frames); end
      end
    end
    checks++; if (words != 12) begin failures++; $display("FAIL basic_words got=%0d want=12", words); end
    checks++; if (dones != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", dones); end
    checks++; if (done_cyc != last_cyc) begin failures++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, last_cyc); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL basic_gap_cycles got=%0d want=0", gaps); end
    checks++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL basic_done_hold got=%b/%b want=1/0", busy, m_axis_tvalid); end
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_len_zero();
    int words, dones;
    frame_len = 16'd0; num_frames = 32'd2; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    words = 0; dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data || m_axis_tlast !== 1'b1) begin
          failures++; $display("FAIL len0_word got=%0d/%b want=%0d/1", m_axis_tdata, m_axis_tlast, exp_data); end
        exp_data++; exp_frames++; words++;
      end
      step();
      if (done) dones++;
    end
    checks++; if (words != 2 || dones != 1) begin failures++; $display("FAIL len0_counts got=%0d/%0d want=2/1", words, dones); end
    checks++; if (frames_sent !== exp_frames) begin failures++; $display("FAIL len0_frames got=%0d want=%0d", frames_sent, exp_frames); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    logic        prev_stall, prev_last;
    logic [31:0] prev_data;
    int words, dones;
    pat = 16'b1011_0010_1110_0110;
    frame_len = 16'd8; num_frames = 32'd2; enable = 1'b1; m_axis_tready = 1'b0;
    step();
    words = 0; dones = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int c = 0; c < 80; c++) begin
      m_axis_tready = pat[c % 16];
      if (prev_stall) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          failures++; $display("FAIL bp_stable got=%b/%0d/%b want=1/%0d/%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last); end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data) begin failures++; $display("FAIL bp_data got=%0d want=%0d", m_axis_tdata, exp_data); end
        checks++; if (m_axis_tlast !== ((words % 8) == 7)) begin failures++; $display("FAIL bp_tlast word=%0d got=%b", words, m_axis_tlast); end
        if (m_axis_tlast) exp_frames++;
        exp_data++; words++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      step();
      if (done) dones++;
    end
    checks++; if (words != 16 || dones != 1) begin failures++; $display("FAIL bp_counts got=%0d/%0d want=16/1", words, dones); end
    m_axis_tready = 1'b1; enable = 1'b0;
    step();
  endtask

  task automatic test_enable_drop();
    int words, dones, late;
    frame_len = 16'd6; num_frames = 32'd0; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    words = 0; dones = 0; late = 0;
    for (int c = 0; c < 60; c++) begin
      if (m_axis_tvalid && words >= 30) late++;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data) begin failures++; $display("FAIL drop_data got=%0d want=%0d", m_axis_tdata, exp_data); end
        checks++; if (m_axis_tlast !== ((words % 6) == 5)) begin failures++; $display("FAIL drop_tlast word=%0d got=%b", words, m_axis_tlast); end
        if (m_axis_tlast) exp_frames++;
        exp_data++; words++;
        if (words == 26) enable = 1'b0;
      end
      step();
      if (done) dones++;
    end
    checks++; if (words != 30) begin failures++; $display("FAIL drop_words got=%0d want=30", words); end
    checks++; if (late != 0) begin failures++; $display("FAIL drop_late_valid got=%0d want=0", late); end
    checks++; if (busy !== 1'b0 || dones != 0) begin failures++; $display("FAIL drop_idle got=%b/%0d want=0/0", busy, dones); end
    checks++; if (frames_sent !== exp_frames) begin failures++; $display("FAIL drop_frames got=%0d want=%0d", frames_sent, exp_frames); end
  endtask

`ifdef AXIS_FRAME_GEN_GAP_EN
  task automatic test_gap();
    int words, gaps;
    frame_len = 16'd2; num_frames = 32'd2; gap_cycles = 16'd3; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    words = 0; gaps = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data) begin failures++; $display("FAIL gap_data got=%0d want=%0d", m_axis_tdata, exp_data); end
        if (m_axis_tlast) exp_frames++;
        exp_data++; words++;
      end else if (words > 0 && words < 4) gaps++;
      step();
    end
    checks++; if (words != 4 || gaps != 3) begin failures++; $display("FAIL gap_cycles got=%0d/%0d want=4/3", words, gaps); end
    gap_cycles = 16'd0; enable = 1'b0;
    step();
  endtask
`endif

  task automatic test_async_reset();
    int words, dones;
    frame_len = 16'd4; num_frames = 32'd0; m_axis_tready = 1'b1; enable = 1'b1;
    step();
    repeat (5) step();
    #2 areset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b/%b want=0/0", m_axis_tvalid, m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'd0 || frames_sent !== 32'd0) begin failures++; $display("FAIL arst_regs got=%0d/%0d want=0/0", m_axis_tdata, frames_sent); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL arst_status got=%b/%b want=0/0", busy, done); end
    enable = 1'b0;
    step();
    areset = 1'b0;
    exp_data = 32'd0; exp_frames = 32'd0;
    step();
    frame_len = 16'd3; num_frames = 32'd1; enable = 1'b1;
    step();
    words = 0; dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_data) begin failures++; $display("FAIL arst_restart_data got=%0d want=%0d", m_axis_tdata, exp_data); end
        if (m_axis_tlast) exp_frames++;
        exp_data++; words++;
      end
      step();
      if (done) dones++;
    end
    checks++; if (words != 3 || dones != 1 || frames_sent !== exp_frames) begin
      failures++; $display("FAIL arst_restart got=%0d/%0d/%0d want=3/1/%0d", words, dones, frames_sent, exp_frames); end
    enable = 1'b0;
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_data = 32'd0; exp_frames = 32'd0;
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_enable_drop();
`ifdef AXIS_FRAME_GEN_GAP_EN
    test_gap();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
